cache_ctrl_wb: RTL and testbench

- Parametrised set-associative, write-back, write-allocate cache controller with true-LRU replacement.
- Successor to the fixed 4-way, internal-memory cache FSM. Way count, set count and block size are parameters.
- Backing store is external, reached through a block-aligned command port and word-serial data beats.
- Sits between a single CPU load/store port and the memory arbiter. Includes hit/miss/writeback statistics counters.

---
 rtl/cache_ctrl_wb.sv | 250 +++++++++++++++++++++++++
 tb/tb_cache_ctrl_wb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl_wb.sv
// Set-associative write-back / write-allocate cache controller with true-LRU replacement.
// Latency: hit accept-to-resp_valid 2 cycles; miss adds command stall + optional writeback + fill beats.
// Backpressure: req_ready only in IDLE; memory command/writeback beats wait for ready, fill beats never stall.
module cache_ctrl_wb #(
   parameter int ADDRESS_WIDTH   = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int SETS            = 64,
   parameter int WAY             = 4,
   parameter int WORDS_PER_BLOCK = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_write,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic                     mem_req_valid,
   input  logic                     mem_req_ready,
   output logic                     mem_req_write,
   output logic [ADDRESS_WIDTH-1:0] mem_req_addr,
   output logic                     mem_wvalid,
   input  logic                     mem_wready,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   input  logic                     mem_rvalid,
   input  logic [DATA_WIDTH-1:0]    mem_rdata,
   output logic [31:0]              hit_count,
   output logic [31:0]              miss_count,
   output logic [31:0]              wb_count
);

   localparam int BYTE_OFFSET  = $clog2(DATA_WIDTH / 8);
   localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
   localparam int SET_WIDTH    = $clog2(SETS);
   localparam int TAG_WIDTH    = ADDRESS_WIDTH - SET_WIDTH - OFFSET_WIDTH - BYTE_OFFSET;
   localparam int AGE_WIDTH    = $clog2(WAY);
   localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = OFFSET_WIDTH'(WORDS_PER_BLOCK - 1);
   localparam logic [AGE_WIDTH-1:0]    OLDEST    = AGE_WIDTH'(WAY - 1);

   typedef enum logic [2:0] {IDLE, LOOKUP, WB_REQ, WB_DATA, FILL_REQ, FILL, RESP} state_t;

   state_t                  state;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [SET_WIDTH-1:0]    set_q;
   logic [OFFSET_WIDTH-1:0] off_q;
   logic                    write_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [AGE_WIDTH-1:0]    victim;
   logic [OFFSET_WIDTH-1:0] beat;
   logic [DATA_WIDTH-1:0]   fill_word;

   logic [DATA_WIDTH-1:0] data_arr  [WAY][SETS][WORDS_PER_BLOCK];
   logic [TAG_WIDTH-1:0]  tag_arr   [WAY][SETS];
   logic                  valid_arr [WAY][SETS];
   logic                  dirty_arr [WAY][SETS];
   logic [AGE_WIDTH-1:0]  age_arr   [WAY][SETS];

   logic                    hit;
   logic [AGE_WIDTH-1:0]    hit_way;
   logic                    found_inv;
   logic [AGE_WIDTH-1:0]    victim_sel;
   logic [AGE_WIDTH-1:0]    touch_way;
   logic [DATA_WIDTH-1:0]   beat_word;
   logic [OFFSET_WIDTH-1:0] beat_nxt;

   assign req_ready = (state == IDLE);
   assign beat_nxt  = beat + OFFSET_WIDTH'(1);

   // Byte-lane address bits are don't-care for word accesses.
   generate
      if (BYTE_OFFSET > 0) begin : g_byte_bits
         logic unused_byte_bits;
         assign unused_byte_bits = ^req_addr[BYTE_OFFSET-1:0];
      end
   endgenerate

   // New age of one way when way touch is accessed: younger ways age by one, touched way becomes 0.
   function automatic logic [AGE_WIDTH-1:0] lru_next(input logic [AGE_WIDTH-1:0] cur,
                                                     input logic [AGE_WIDTH-1:0] touched_age,
                                                     input logic             is_touched);
      if (is_touched)             return '0;
      else if (cur < touched_age) return cur + AGE_WIDTH'(1);
      else                        return cur;
   endfunction

   // Tag match, victim choice and fill-beat merge for the latched request.
   always_comb begin
      hit        = 1'b0;
      hit_way    = '0;
      found_inv  = 1'b0;
      victim_sel = '0;
      for (int w = 0; w < WAY; w++) begin
         if (!hit && valid_arr[w][set_q] && tag_arr[w][set_q] == tag_q) begin
            hit     = 1'b1;
            hit_way = AGE_WIDTH'(w);
         end
      end
      for (int w = 0; w < WAY; w++) begin
         if (!found_inv && !valid_arr[w][set_q]) begin
            found_inv  = 1'b1;
            victim_sel = AGE_WIDTH'(w);
         end
      end
      if (!found_inv) begin
         for (int w = 0; w < WAY; w++) begin
            if (age_arr[w][set_q] == OLDEST) victim_sel = AGE_WIDTH'(w);
         end
      end
      touch_way = (state == FILL) ? victim : hit_way;
      // On a store miss the CPU word replaces the fill word at the request offset.
      beat_word = (write_q && beat == off_q) ? wdata_q : mem_rdata;
   end

   // Controller FSM, line state arrays, registered outputs and statistics.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         tag_q         <= '0;
         set_q         <= '0;
         off_q         <= '0;
         write_q       <= 1'b0;
         wdata_q       <= '0;
         victim        <= '0;
         beat          <= '0;
         fill_word     <= '0;
         resp_valid    <= 1'b0;
         resp_rdata    <= '0;
         mem_req_valid <= 1'b0;
         mem_req_write <= 1'b0;
         mem_req_addr  <= '0;
         mem_wvalid    <= 1'b0;
         mem_wdata     <= '0;
         hit_count     <= '0;
         miss_count    <= '0;
         wb_count      <= '0;
         for (int w = 0; w < WAY; w++) begin
            for (int s = 0; s < SETS; s++) begin
               valid_arr[w][s] <= 1'b0;
               dirty_arr[w][s] <= 1'b0;
               age_arr[w][s]   <= AGE_WIDTH'(w);
            end
         end
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  tag_q   <= req_addr[ADDRESS_WIDTH-1 -: TAG_WIDTH];
                  set_q   <= req_addr[BYTE_OFFSET+OFFSET_WIDTH +: SET_WIDTH];
                  off_q   <= req_addr[BYTE_OFFSET +: OFFSET_WIDTH];
                  write_q <= req_write;
                  wdata_q <= req_wdata;
                  state   <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  if (write_q) begin
                     data_arr[hit_way][set_q][off_q] <= wdata_q;
                     dirty_arr[hit_way][set_q]       <= 1'b1;
                     resp_rdata                      <= wdata_q;
                  end else begin
                     resp_rdata <= data_arr[hit_way][set_q][off_q];
                  end
                  for (int w = 0; w < WAY; w++)
                     age_arr[w][set_q] <= lru_next(age_arr[w][set_q], age_arr[touch_way][set_q],
                                                   AGE_WIDTH'(w) == touch_way);
                  if (hit_count != 32'hFFFF_FFFF) hit_count <= hit_count + 32'd1;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  if (miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
                  victim        <= victim_sel;
                  beat          <= '0;
                  mem_req_valid <= 1'b1;
                  if (valid_arr[victim_sel][set_q] && dirty_arr[victim_sel][set_q]) begin
                     mem_req_write <= 1'b1;
                     mem_req_addr  <= {tag_arr[victim_sel][set_q], set_q,
                                       {(OFFSET_WIDTH+BYTE_OFFSET){1'b0}}};
                     state         <= WB_REQ;
                  end else begin
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= {tag_q, set_q, {(OFFSET_WIDTH+BYTE_OFFSET){1'b0}}};
                     state         <= FILL_REQ;
                  end
               end
            end
            WB_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  mem_wvalid    <= 1'b1;
                  mem_wdata     <= data_arr[victim][set_q][0];
                  beat          <= '0;
                  state         <= WB_DATA;
               end
            end
            WB_DATA: begin
               if (mem_wready) begin
                  if (beat == LAST_BEAT) begin
                     mem_wvalid               <= 1'b0;
                     dirty_arr[victim][set_q] <= 1'b0;
                     if (wb_count != 32'hFFFF_FFFF) wb_count <= wb_count + 32'd1;
                     beat          <= '0;
                     mem_req_valid <= 1'b1;
                     mem_req_write <= 1'b0;
                     mem_req_addr  <= {tag_q, set_q, {(OFFSET_WIDTH+BYTE_OFFSET){1'b0}}};
                     state         <= FILL_REQ;
                  end else begin
                     beat      <= beat_nxt;
                     mem_wdata <= data_arr[victim][set_q][beat_nxt];
                  end
               end
            end
            FILL_REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  beat          <= '0;
                  state         <= FILL;
               end
            end
            FILL: begin
               if (mem_rvalid) begin
                  data_arr[victim][set_q][beat] <= beat_word;
                  if (beat == off_q) fill_word <= beat_word;
                  if (beat == LAST_BEAT) begin
                     tag_arr[victim][set_q]   <= tag_q;
                     valid_arr[victim][set_q] <= 1'b1;
                     dirty_arr[victim][set_q] <= write_q;
                     resp_rdata <= (off_q == LAST_BEAT) ? beat_word : fill_word;
                     for (int w = 0; w < WAY; w++)
                        age_arr[w][set_q] <= lru_next(age_arr[w][set_q], age_arr[touch_way][set_q],
                                                      AGE_WIDTH'(w) == touch_way);
                     resp_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     beat <= beat_nxt;
                  end
               end
            end
            RESP: begin
               resp_valid <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_ctrl_wb.sv
// Directed table-driven bench for cache_ctrl_wb with a behavioural memory responder.
// Expected read data, traffic and counter values are hand-derived in the vector table.
// The responder can stall commands and toggle writeback ready to exercise backpressure.
module tb_cache_ctrl_wb;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        mem_req_valid;
   logic        mem_req_ready = 1'b0;
   logic        mem_req_write;
   logic [31:0] mem_req_addr;
   logic        mem_wvalid;
   logic        mem_wready = 1'b0;
   logic [31:0] mem_wdata;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic [31:0] hit_count, miss_count, wb_count;

   cache_ctrl_wb dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
   );

   initial forever #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory model and responder ----------------
   logic [31:0] mem_m [int];
   logic [31:0] cmd_addr_q [$];
   bit          cmd_wr_q [$];
   logic [31:0] wb_q [$];
   int          cur_stall = 0;
   bit          tog = 1'b0;
   int          fidx = 0;

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_m.exists(int'(a >> 2))) return mem_m[int'(a >> 2)];
      return 32'h1000_0000 | a;
   endfunction

   initial begin
      int          fill_left = 0;
      int          wb_idx = 0;
      int          stall_left = 0;
      bit          seen = 1'b0;
      bit          tog_phase = 1'b0;
      bit          acc_write = 1'b0;
      bit          s_wr = 1'b0;
      logic [31:0] acc_addr = '0;
      logic [31:0] s_addr = '0;
      logic [31:0] fill_addr = '0;
      logic [31:0] wb_base = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mem_req_ready = 1'b0;
            mem_rvalid    = 1'b0;
            mem_wready    = 1'b0;
            fill_left     = 0;
            seen          = 1'b0;
         end else begin
            // command channel
            if (mem_req_ready) begin
               mem_req_ready = 1'b0;
               seen = 1'b0;
               if (acc_write) begin
                  wb_idx = 0; tog_phase = 1'b0; wb_base = acc_addr;
               end else begin
                  fill_left = 4; fidx = 0; fill_addr = acc_addr;
               end
            end else if (mem_req_valid) begin
               if (!seen) begin
                  seen = 1'b1; s_addr = mem_req_addr; s_wr = mem_req_write; stall_left = cur_stall;
               end else begin
                  chk("cmd_addr_stable", mem_req_addr, s_addr);
                  chk("cmd_write_stable", 32'(mem_req_write), 32'(s_wr));
               end
               if (stall_left == 0) begin
                  mem_req_ready = 1'b1;
                  acc_addr  = mem_req_addr;
                  acc_write = mem_req_write;
                  cmd_addr_q.push_back(mem_req_addr);
                  cmd_wr_q.push_back(mem_req_write);
               end else begin
                  stall_left--;
               end
            end
            // fill beats, one per cycle
            if (fill_left > 0) begin
               mem_rvalid = 1'b1;
               mem_rdata  = mem_rd(fill_addr + 32'(4 * fidx));
               fidx++;
               fill_left--;
            end else begin
               mem_rvalid = 1'b0;
               mem_rdata  = 32'hBAD0_BAD0;
            end
            // writeback beats, optionally every other cycle
            mem_wready = 1'b0;
            if (mem_wvalid) begin
               if (!tog || tog_phase) begin
                  mem_wready = 1'b1;
                  wb_q.push_back(mem_wdata);
                  mem_m[int'(wb_base >> 2) + wb_idx] = mem_wdata;
                  wb_idx++;
               end
               tog_phase = ~tog_phase;
            end
         end
      end
   end

   // ---------------- request driver ----------------
   task automatic do_req(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat, output bit ok);
      ok = 1'b0; rd = '0;
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0; req_write = ~wr; req_addr = 32'hFFFF_FFFF; req_wdata = 32'hFFFF_FFFF;
      lat = 1;
      while (lat < 300 && !resp_valid) begin
         @(negedge clk);
         lat++;
      end
      if (resp_valid) begin
         ok = 1'b1;
         rd = resp_rdata;
      end
      @(negedge clk);
      chk("resp_pulse_one_cycle", 32'(resp_valid), 32'd0);
   endtask

   typedef struct {
      bit               wr;
      logic [31:0]      addr;
      logic [31:0]      wdata;
      logic [31:0]      exp_rd;
      bit               exp_hit;
      bit               exp_wb;
      logic [31:0]      wb_addr;
      logic [3:0][31:0] wbd;
      int               stall;
      bit               tog;
   } vec_t;

   function automatic vec_t mk(input bit wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] rd, input bit h, input bit w,
                               input logic [31:0] wa, input logic [127:0] wbd,
                               input int stall, input bit tg);
      vec_t v;
      v.wr = wr; v.addr = a; v.wdata = d; v.exp_rd = rd; v.exp_hit = h; v.exp_wb = w;
      v.wb_addr = wa; v.wbd = wbd; v.stall = stall; v.tog = tg;
      return v;
   endfunction

   int exp_h = 0, exp_m = 0, exp_w = 0;

   task automatic apply_vec(input int idx, input vec_t v);
      logic [31:0] rd;
      int          lat;
      bit          ok;
      int          ncmd;
      cur_stall = v.stall;
      tog       = v.tog;
      cmd_addr_q.delete(); cmd_wr_q.delete(); wb_q.delete();
      do_req(v.wr, v.addr, v.wdata, rd, lat, ok);
      if (v.exp_hit) exp_h++; else exp_m++;
      if (v.exp_wb) exp_w++;
      chk($sformatf("v%0d_resp_seen", idx), 32'(ok), 32'd1);
      chk($sformatf("v%0d_rdata", idx), rd, v.exp_rd);
      ncmd = v.exp_hit ? 0 : (v.exp_wb ? 2 : 1);
      chk($sformatf("v%0d_mem_cmds", idx), 32'(cmd_addr_q.size()), 32'(ncmd));
      if (v.exp_hit) chk($sformatf("v%0d_hit_latency", idx), 32'(lat), 32'd2);
      if (!v.exp_hit && cmd_addr_q.size() == ncmd) begin
         chk($sformatf("v%0d_fill_addr", idx), cmd_addr_q[ncmd-1], {v.addr[31:4], 4'h0});
         chk($sformatf("v%0d_fill_wr", idx), 32'(cmd_wr_q[ncmd-1]), 32'd0);
      end
      if (v.exp_wb && cmd_addr_q.size() == 2) begin
         chk($sformatf("v%0d_wb_addr", idx), cmd_addr_q[0], v.wb_addr);
         chk($sformatf("v%0d_wb_wr", idx), 32'(cmd_wr_q[0]), 32'd1);
         chk($sformatf("v%0d_wb_beats", idx), 32'(wb_q.size()), 32'd4);
         if (wb_q.size() == 4)
            for (int b = 0; b < 4; b++)
               chk($sformatf("v%0d_wb_beat%0d", idx, b), wb_q[b], v.wbd[b]);
      end
      chk($sformatf("v%0d_hit_count", idx), hit_count, 32'(exp_h));
      chk($sformatf("v%0d_miss_count", idx), miss_count, 32'(exp_m));
      chk($sformatf("v%0d_wb_count", idx), wb_count, 32'(exp_w));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      chk({tag, "_mem_req_valid"}, 32'(mem_req_valid), 32'd0);
      chk({tag, "_mem_req_write"}, 32'(mem_req_write), 32'd0);
      chk({tag, "_mem_req_addr"}, mem_req_addr, 32'd0);
      chk({tag, "_mem_wvalid"}, 32'(mem_wvalid), 32'd0);
      chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, "_hit_count"}, hit_count, 32'd0);
      chk({tag, "_miss_count"}, miss_count, 32'd0);
      chk({tag, "_wb_count"}, wb_count, 32'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl [20];
      bit   saw_beat2;
      // set 1 = 0x10, set 2 = 0x20; tag t at byte address t*0x400 + set*0x10
      tbl[0]  = mk(0, 32'h0010, 0,            32'h0000_00A0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 32'h0010, 0,            32'h0000_00A0, 1, 0, 0, 0, 0, 0);
      tbl[2]  = mk(1, 32'h0014, 32'hDEADBEEF, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
      tbl[3]  = mk(0, 32'h0014, 0,            32'hDEAD_BEEF, 1, 0, 0, 0, 0, 0);
      tbl[4]  = mk(0, 32'h0410, 0,            32'h1000_0410, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(0, 32'h0810, 0,            32'h1000_0810, 0, 0, 0, 0, 0, 0);
      tbl[6]  = mk(0, 32'h0C10, 0,            32'h1000_0C10, 0, 0, 0, 0, 0, 0);
      tbl[7]  = mk(0, 32'h1010, 0,            32'h1000_1010, 0, 1, 32'h0010,
                   {32'hA3, 32'hA2, 32'hDEADBEEF, 32'hA0}, 7, 1);
      tbl[8]  = mk(0, 32'h0014, 0,            32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);
      tbl[9]  = mk(1, 32'h0028, 32'h55,       32'h0000_0055, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(0, 32'h0028, 0,            32'h0000_0055, 1, 0, 0, 0, 0, 0);
      tbl[11] = mk(0, 32'h0020, 0,            32'h0000_0097, 1, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 32'h002C, 0,            32'h0000_009A, 1, 0, 0, 0, 0, 0);
      tbl[13] = mk(0, 32'h0428, 0,            32'h1000_0428, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(0, 32'h0828, 0,            32'h1000_0828, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk(0, 32'h0C28, 0,            32'h1000_0C28, 0, 0, 0, 0, 0, 0);
      tbl[16] = mk(0, 32'h1028, 0,            32'h1000_1028, 0, 1, 32'h0020,
                   {32'h9A, 32'h55, 32'h98, 32'h97}, 2, 0);
      tbl[17] = mk(0, 32'h0028, 0,            32'h0000_0055, 0, 0, 0, 0, 0, 0);
      // after the mid-fill reset every line is invalid again
      tbl[18] = mk(0, 32'h0030, 0,            32'h1000_0030, 0, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 32'h0014, 0,            32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0);

      mem_m[4] = 32'hA0; mem_m[5]  = 32'hA1; mem_m[6]  = 32'hA2; mem_m[7]  = 32'hA3;
      mem_m[8] = 32'h97; mem_m[9]  = 32'h98; mem_m[10] = 32'h99; mem_m[11] = 32'h9A;

      repeat (3) @(negedge clk);
      chk_reset_outputs("por");
      reset = 1'b0;
      @(negedge clk);
      chk("por_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 18; i++) apply_vec(i, tbl[i]);

      // reset while the second fill beat of a miss is on the bus
      cur_stall = 0; tog = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0030; req_wdata = '0;
      @(negedge clk);
      req_valid = 1'b0;
      saw_beat2 = 1'b0;
      for (int k = 0; k < 50 && !saw_beat2; k++) begin
         @(negedge clk);
         #1;
         if (fidx == 2) saw_beat2 = 1'b1;
      end
      chk("rst_fill_beat2_reached", 32'(saw_beat2), 32'd1);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk_reset_outputs("midrst");
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      exp_h = 0; exp_m = 0; exp_w = 0;
      for (int i = 18; i < 20; i++) apply_vec(i, tbl[i]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
